// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the N-way write-back cache.
package cache_pkg;

  localparam int unsigned LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  function automatic int unsigned tag_bits(input int unsigned s_offset, input int unsigned s_index);
    return 32 - s_offset - s_index;
  endfunction

  function automatic int unsigned index_bits(input int unsigned s_index);
    return s_index;
  endfunction

  function automatic int unsigned way_bits(input int unsigned num_ways);
    return $clog2(num_ways);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: next node bits after touching a way, and the way the node bits point at.
module plru_tree #(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         bits,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  output logic [NUM_WAYS-2:0]         next_bits,
  output logic [$clog2(NUM_WAYS)-1:0] victim
);
  localparam int unsigned LEVELS = $clog2(NUM_WAYS);

  // Heap numbering: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
  always_comb begin
    int unsigned tnode;
    int unsigned vnode;
    logic        dir;
    logic        pick;
    next_bits = bits;
    victim    = '0;
    tnode     = 0;
    vnode     = 0;
    dir       = 1'b0;
    pick      = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      dir  = touch_way[LEVELS-1-l];
      pick = 1'b0;
      for (int unsigned n = 0; n < NUM_WAYS - 1; n++) begin
        if (n == tnode) next_bits[n] = ~dir;
        if (n == vnode) pick = bits[n];
      end
      victim[LEVELS-1-l] = pick;
      tnode = 2 * tnode + 1 + (dir ? 1 : 0);
      vnode = 2 * vnode + 1 + (pick ? 1 : 0);
    end
  end
endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree-PLRU replacement.
module cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_byte_enable256,
  input  logic [LINE_BITS-1:0] mem_wdata256,
  output logic [LINE_BITS-1:0] mem_rdata256,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic                 pmem_resp
);
  localparam int unsigned TAG_W = tag_bits(S_OFFSET, S_INDEX);
  localparam int unsigned IDX_W = index_bits(S_INDEX);
  localparam int unsigned WAY_W = way_bits(NUM_WAYS);
  localparam int unsigned SETS  = 1 << S_INDEX;

  state_t                 state;
  logic [NUM_WAYS-1:0]    valid [SETS];
  logic [NUM_WAYS-1:0]    dirty [SETS];
  logic [NUM_WAYS-2:0]    plru  [SETS];
  logic [TAG_W-1:0]       tags  [SETS][NUM_WAYS];
  logic [LINE_BITS-1:0]   data  [SETS][NUM_WAYS];

  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic                   any_invalid;
  logic [WAY_W-1:0]       invalid_way;
  logic [WAY_W-1:0]       plru_victim;
  logic [WAY_W-1:0]       victim_way;
  logic [WAY_W-1:0]       victim_q;
  logic [NUM_WAYS-2:0]    plru_next;
  logic                   unused_offset;

  assign index         = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_tag       = mem_address[31:S_OFFSET+S_INDEX];
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    invalid_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid[index][w] && tags[index][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!any_invalid && !valid[index][w]) begin
        any_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits      (plru[index]),
    .touch_way (hit_way),
    .next_bits (plru_next),
    .victim    (plru_victim)
  );

  assign victim_way   = any_invalid ? invalid_way : plru_victim;
  assign mem_resp     = (state == CHECK) && hit;
  assign mem_rdata256 = data[index][hit_way];
  assign pmem_write   = (state == WRITEBACK);
  assign pmem_read    = (state == FILL);
  assign pmem_wdata   = data[index][victim_q];
  assign pmem_address = (state == WRITEBACK) ? {tags[index][victim_q], index, {S_OFFSET{1'b0}}}
                                             : {req_tag, index, {S_OFFSET{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      victim_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (mem_read || mem_write) state <= CHECK;
        CHECK: begin
          if (hit) begin
            plru[index] <= plru_next;
            if (mem_write) dirty[index][hit_way] <= 1'b1;
            state <= IDLE;
          end else begin
            victim_q <= victim_way;
            state    <= (valid[index][victim_way] && dirty[index][victim_way]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) state <= FILL;
        FILL: begin
          if (pmem_resp) begin
            valid[index][victim_q] <= 1'b1;
            dirty[index][victim_q] <= 1'b0;
            state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; their contents only matter behind a set valid bit.
  always_ff @(posedge clk) begin
    if (state == FILL && pmem_resp) begin
      data[index][victim_q] <= pmem_rdata;
      tags[index][victim_q] <= req_tag;
    end else if (state == CHECK && hit && mem_write) begin
      for (int unsigned b = 0; b < LINE_BITS / 8; b++) begin
        if (mem_byte_enable256[b]) data[index][hit_way][8*b +: 8] <= mem_wdata256[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway with a set/way/PLRU reference model and a pmem responder.
module tb_cache_nway;
  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_INDEX  = 3;
  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned SETS     = 8;
  localparam int unsigned LEVELS   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256, mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_rdata, pmem_wdata;
  logic         pmem_resp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_nway #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
    .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = a ^ (32'h1357_0000 + 32'(k) * 32'h0101_0101);
    return l;
  endfunction

  // Reference model: contents per set/way, PLRU kept as node bits per (level, group).
  bit           m_valid [SETS][NUM_WAYS];
  bit           m_dirty [SETS][NUM_WAYS];
  logic [23:0]  m_tag   [SETS][NUM_WAYS];
  logic [255:0] m_data  [SETS][NUM_WAYS];
  bit           m_node  [SETS][LEVELS][NUM_WAYS/2];
  logic [255:0] model_mem [logic [31:0]];
  logic [255:0] phys_mem  [logic [31:0]];

  bit           exp_fill, exp_wb, exp_read, req_active;
  logic [31:0]  exp_fill_addr, exp_wb_addr;
  logic [255:0] exp_wb_data, exp_rdata;
  bit           saw_fill, saw_wb, wb_before_fill;
  logic [31:0]  last_fill_addr, last_wb_addr;
  logic [255:0] last_wb_data, last_rdata;

  bit  hold = 1'b0;
  int  inject_cnt = 0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        if (w < NUM_WAYS / 2) for (int l = 0; l < LEVELS; l++) m_node[s][l][w] = 1'b0;
      end
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] be,
                              input logic [255:0] wd);
    int s, way;
    bit found, inv;
    logic [23:0] t;
    s = int'(a[7:5]);
    t = a[31:8];
    found = 1'b0; inv = 1'b0; way = 0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!found && m_valid[s][w] && m_tag[s][w] == t) begin found = 1'b1; way = w; end
    exp_fill = !found;
    exp_wb = 1'b0;
    exp_fill_addr = {t, a[7:5], 5'b0};
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (!inv && !m_valid[s][w]) begin inv = 1'b1; way = w; end
      if (!inv) begin
        way = 0;
        for (int l = 0; l < LEVELS; l++) way = way * 2 + (m_node[s][l][way] ? 1 : 0);
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        exp_wb = 1'b1;
        exp_wb_addr = {m_tag[s][way], a[7:5], 5'b0};
        exp_wb_data = m_data[s][way];
        model_mem[exp_wb_addr] = m_data[s][way];
      end
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way] = t;
      m_data[s][way] = model_mem.exists(exp_fill_addr) ? model_mem[exp_fill_addr] : pattern(exp_fill_addr);
    end
    for (int l = 0; l < LEVELS; l++)
      m_node[s][l][way >> (LEVELS - l)] = (((way >> (LEVELS - 1 - l)) & 1) == 0);
    if (wr) begin
      for (int b = 0; b < 32; b++) if (be[b]) m_data[s][way][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][way] = 1'b1;
    end
    exp_read = !wr;
    exp_rdata = m_data[s][way];
  endtask

  // Compare process: pmem exclusivity, transfer addresses/data, and returned read data.
  always @(negedge clk) begin
    if (rst) begin
      chk("pmem_exclusive", 256'(pmem_read & pmem_write), '0);
      if (pmem_write) begin
        saw_wb = 1'b1;
        last_wb_addr = pmem_address;
        last_wb_data = pmem_wdata;
        chk("wb_expected", 256'(exp_wb), 256'(1));
        chk("wb_addr", 256'(pmem_address), 256'(exp_wb_addr));
        chk("wb_data", pmem_wdata, exp_wb_data);
      end
      if (pmem_read) begin
        if (!saw_fill) wb_before_fill = saw_wb;
        saw_fill = 1'b1;
        last_fill_addr = pmem_address;
        chk("fill_expected", 256'(exp_fill), 256'(1));
        chk("fill_addr", 256'(pmem_address), 256'(exp_fill_addr));
      end
      if (mem_resp) begin
        last_rdata = mem_rdata256;
        chk("resp_expected", 256'(req_active), 256'(1));
        if (exp_read) chk("rdata", mem_rdata256, exp_rdata);
      end
    end else begin
      chk("reset_outputs", 256'({mem_resp, pmem_read, pmem_write}), '0);
    end
  end

  // Memory responder: answers after a short delay, plus on-demand stray pulses.
  initial begin
    int wait_cnt;
    int inject_done;
    wait_cnt = 0;
    inject_done = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_resp) pmem_resp = 1'b0;
      else if (inject_done != inject_cnt) begin
        inject_done++;
        pmem_resp = 1'b1;
        pmem_rdata = '1;
      end else if (hold) wait_cnt = 0;
      else if (pmem_read || pmem_write) begin
        if (wait_cnt < 2) wait_cnt++;
        else begin
          wait_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) phys_mem[pmem_address] = pmem_wdata;
          else pmem_rdata = phys_mem.exists(pmem_address) ? phys_mem[pmem_address] : pattern(pmem_address);
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] be,
                        input logic [255:0] wd, output int lat, output bit fill, output bit wb);
    model_access(a, wr, be, wd);
    saw_fill = 1'b0; saw_wb = 1'b0; wb_before_fill = 1'b0;
    mem_address = a; mem_byte_enable256 = be; mem_wdata256 = wd;
    mem_read = rd; mem_write = wr; req_active = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < 200);
    if (!mem_resp) chk("resp_timeout", 256'(mem_resp), 256'(1));
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; req_active = 1'b0;
    chk("saw_fill", 256'(saw_fill), 256'(exp_fill));
    chk("saw_wb", 256'(saw_wb), 256'(exp_wb));
    if (!exp_fill) chk("hit_latency", 256'(lat), 256'(2));
    fill = saw_fill;
    wb = saw_wb;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    bit f, w;
    logic [255:0] line, exp_line;
    rst = 1'b0;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable256 = '0; mem_wdata256 = '0;
    req_active = 1'b0; exp_read = 1'b0; exp_fill = 1'b0; exp_wb = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    chk("reset_mem_resp", 256'(mem_resp), '0);
    chk("reset_pmem", 256'({pmem_read, pmem_write}), '0);
    #1 rst = 1'b1;

    // Cold read: fill only, data from memory.
    access(32'h40, 1, 0, '0, '0, lat, f, w);
    chk("cold_fill", 256'(f), 256'(1));
    chk("cold_no_wb", 256'(w), '0);
    chk("cold_fill_addr", 256'(last_fill_addr), 256'(32'h0000_0040));
    chk("cold_rdata", last_rdata, pattern(32'h40));
    access(32'h40, 1, 0, '0, '0, lat, f, w);
    chk("hit_lat2", 256'(lat), 256'(2));
    chk("hit_pmem_idle", 256'({f, w}), '0);

    // Fill all four ways of set 2, hit 0,1,2, then miss; model predicts the victim.
    access(32'h140, 1, 0, '0, '0, lat, f, w);
    access(32'h240, 1, 0, '0, '0, lat, f, w);
    access(32'h340, 1, 0, '0, '0, lat, f, w);
    access(32'h40,  1, 0, '0, '0, lat, f, w);
    access(32'h140, 1, 0, '0, '0, lat, f, w);
    access(32'h240, 1, 0, '0, '0, lat, f, w);
    access(32'h440, 1, 0, '0, '0, lat, f, w);
    // Hits on ways 2,0,1 leave the tree pointing at way 3 (tag 3).
    access(32'h240, 1, 0, '0, '0, lat, f, w);
    access(32'h440, 1, 0, '0, '0, lat, f, w);
    access(32'h140, 1, 0, '0, '0, lat, f, w);
    access(32'h540, 1, 0, '0, '0, lat, f, w);
    access(32'h340, 1, 0, '0, '0, lat, f, w);
    chk("way3_was_evicted", 256'(f), 256'(1));
    access(32'h140, 1, 0, '0, '0, lat, f, w);
    chk("way1_still_resident", 256'(f), '0);

    // Read and write together behave as a write.
    access(32'h140, 1, 1, 32'hF0, {8{32'hDEAD_BEEF}}, lat, f, w);
    access(32'h140, 1, 0, '0, '0, lat, f, w);

    // Dirty line in set 5 gets written back before its replacement fill.
    access(32'hA0, 1, 0, '0, '0, lat, f, w);
    access(32'hA0, 0, 1, 32'h1, 256'hFF, lat, f, w);
    access(32'h1A0, 1, 0, '0, '0, lat, f, w);
    access(32'h2A0, 1, 0, '0, '0, lat, f, w);
    access(32'h3A0, 1, 0, '0, '0, lat, f, w);
    access(32'h4A0, 1, 0, '0, '0, lat, f, w);
    line = pattern(32'hA0);
    exp_line = {line[255:8], 8'hFF};
    chk("evict_wb", 256'(w), 256'(1));
    chk("evict_wb_first", 256'(wb_before_fill), 256'(1));
    chk("evict_wb_addr", 256'(last_wb_addr), 256'(32'h0000_00A0));
    chk("evict_wb_data", last_wb_data, exp_line);
    access(32'hA0, 1, 0, '0, '0, lat, f, w);
    chk("refetch_written_line", last_rdata, exp_line);

    // Reset in mid-fill, then a stray pmem_resp after release.
    model_access(32'hE0, 0, '0, '0);
    saw_fill = 1'b0; saw_wb = 1'b0;
    mem_address = 32'hE0; mem_read = 1'b1; req_active = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_read && n < 50);
    chk("reset_test_fill_started", 256'(pmem_read), 256'(1));
    hold = 1'b1;
    #1 rst = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("async_reset_pmem_read", 256'(pmem_read), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    inject_cnt++;
    repeat (4) @(negedge clk);
    chk("stray_resp_no_mem_resp", 256'(mem_resp), '0);
    chk("stray_resp_idle", 256'({pmem_read, pmem_write}), '0);
    hold = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    access(32'hE0, 1, 0, '0, '0, lat, f, w);
    chk("reread_after_reset_misses", 256'(f), 256'(1));
    access(32'h40, 1, 0, '0, '0, lat, f, w);
    chk("reset_cleared_valid", 256'(f), 256'(1));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
